// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO, programmable clocks-per-bit divisor,
// status/divisor readback on the data-memory bus.
module uart_tx_periph #(
  parameter int FIFO_DEPTH  = 4,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  adr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [15:0]     div_r, timer_r, timer_s;
  logic [2:0]      bit_r, bit_s;
  logic [7:0]      shift_r, shift_s;
  logic            tx_r, tx_s;
  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [PW-1:0]   wptr_r, rptr_r;
  logic [CW-1:0]   count_r;
  logic            ovf_r;
  logic            pop_s, push_req_s, push_s, full_s, empty_s, busy_s, wr_s;
  logic            unused_s;

  assign wr_s       = sel & we;
  assign push_req_s = wr_s & (adr[3:2] == 2'd0);
  assign full_s     = (count_r == CW'(FIFO_DEPTH));
  assign empty_s    = (count_r == {CW{1'b0}});
  // A push into a full FIFO still fits when the transmitter pops on the same edge.
  assign push_s     = push_req_s & (~full_s | pop_s);
  assign busy_s     = (state_r != IDLE) | ~empty_s;
  assign busy       = busy_s;
  assign tx         = tx_r;
  assign unused_s   = ^{adr[1:0], wdata[31:16]};

  // Register readback, combinational from the address.
  always_comb begin
    rdata = 32'd0;
    case (adr[3:2])
      2'd1:    rdata = {28'd0, ovf_r, empty_s, full_s, busy_s};
      2'd2:    rdata = {16'd0, div_r};
      default: rdata = 32'd0;
    endcase
  end

  // Next-state logic for the serialiser; tx is derived from the next state so it is registered.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    pop_s   = 1'b0;
    tx_s    = 1'b1;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_s = mem_r[rptr_r];
          state_s = START;
          timer_s = div_r - 16'd1;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (timer_r == 16'd0) begin
          state_s = DATA;
          bit_s   = 3'd0;
          timer_s = div_r - 16'd1;
        end else begin
          timer_s = timer_r - 16'd1;
        end
      end
      DATA: begin
        if (timer_r == 16'd0) begin
          timer_s = div_r - 16'd1;
          if (bit_r == 3'd7) begin
            state_s = STOP;
          end else begin
            bit_s   = bit_r + 3'd1;
            shift_s = {1'b0, shift_r[7:1]};
          end
        end else begin
          timer_s = timer_r - 16'd1;
        end
      end
      STOP: begin
        if (timer_r == 16'd0) begin
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_s = mem_r[rptr_r];
            state_s = START;
            timer_s = div_r - 16'd1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          timer_s = timer_r - 16'd1;
        end
      end
      default: state_s = IDLE;
    endcase
    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      default: tx_s = 1'b1;
    endcase
  end

  // FSM, FIFO pointers, divisor and overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      timer_r <= 16'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      tx_r    <= 1'b1;
      div_r   <= 16'(DEFAULT_DIV);
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      if (push_s) wptr_r <= wptr_r + PW'(1);
      if (pop_s)  rptr_r <= rptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (wr_s && adr[3:2] == 2'd2) begin
        div_r <= (wdata[15:0] < 16'd2) ? 16'd2 : wdata[15:0];
      end
      // A new overflow wins over a simultaneous clear.
      if (push_req_s && full_s && !pop_s) begin
        ovf_r <= 1'b1;
      end else if (wr_s && adr[3:2] == 2'd1 && wdata[3]) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_r[wptr_r] <= wdata[7:0];
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed self-checking bench for uart_tx_periph: reset, single frame, back-to-back,
// overflow, divisor clamp/change and mid-frame reset.
module tb_uart_tx_periph;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  adr = 4'h0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  uart_tx_periph #(.FIFO_DEPTH(4), .DEFAULT_DIV(434)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .adr(adr),
    .wdata(wdata), .rdata(rdata), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected line level for frame slot idx: 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    else if (idx >= 9) return 1'b1;
    else return b[idx-1];
  endfunction

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; adr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; adr = 4'h0; wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    adr = a;
    #1;
    d = rdata;
    adr = 4'h0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    bus_read(4'h4, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL reset_status got %h want 4", d); end
    bus_read(4'h8, d);
    checks++; if (d !== 32'd434) begin errors++; $display("FAIL reset_div got %0d want 434", d); end
    bus_read(4'hC, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_rsvd got %h want 0", d); end
  endtask

  task automatic test_single;
    logic [31:0] d;
    bus_write(4'h8, 32'd4);
    bus_write(4'h0, 32'h55);
    bus_read(4'h4, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL single_status got %h want 1", d); end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== exp_bit(8'h55, k / 4)) begin
        errors++; $display("FAIL single_tx k=%0d got %b want %b", k, tx, exp_bit(8'h55, k / 4));
      end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_stop got %b want 1", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_idle_tx got %b want 1", tx); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic        e;
    bus_write(4'h8, 32'd2);
    bus_write(4'h0, 32'hA3);
    bus_write(4'h0, 32'h0F);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      e = (k < 20) ? exp_bit(8'hA3, k / 2) : exp_bit(8'h0F, (k - 20) / 2);
      checks++;
      if (tx !== e) begin errors++; $display("FAIL b2b_tx k=%0d got %b want %b", k, tx, e); end
    end
    @(posedge clk); #1;
    bus_read(4'h4, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL b2b_status got %h want 4", d); end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    int t0;
    logic [7:0] b;
    bus_write(4'h8, 32'd100);
    bus_write(4'h0, 32'h01);
    t0 = cyc;
    for (int i = 2; i <= 6; i++) bus_write(4'h0, 32'(i));
    bus_read(4'h4, d);
    checks++; if (d !== 32'hB) begin errors++; $display("FAIL ovf_status got %h want b", d); end
    bus_write(4'h4, 32'h8);
    bus_read(4'h4, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL ovf_clear got %h want 3", d); end
    for (int j = 0; j < 5; j++) begin
      b = 8'(j + 1);
      for (int s = 0; s < 10; s++) begin
        wait_cyc(t0 + 1 + j * 1000 + s * 100 + 50);
        checks++;
        if (tx !== exp_bit(b, s)) begin
          errors++; $display("FAIL ovf_tx byte=%0d slot=%0d got %b want %b", j + 1, s, tx, exp_bit(b, s));
        end
      end
    end
    wait_cyc(t0 + 5000);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy_last got %b want 1", busy); end
    wait_cyc(t0 + 5001);
    bus_read(4'h4, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL ovf_end_status got %h want 4", d); end
    wait_cyc(t0 + 5100);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL ovf_no_sixth got %b want 1", tx); end
  endtask

  task automatic test_div_change;
    logic [31:0] d;
    logic        e;
    int          idx;
    bus_write(4'h8, 32'd0);
    bus_read(4'h8, d);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL div_clamp got %0d want 2", d); end
    bus_write(4'h0, 32'hC6);
    for (int k = 0; k < 50; k++) begin
      if (k == 9) bus_write(4'h8, 32'd8);
      else begin @(posedge clk); #1; end
      idx = (k < 10) ? k / 2 : 5 + (k - 10) / 8;
      e = exp_bit(8'hC6, idx);
      checks++;
      if (tx !== e) begin errors++; $display("FAIL div_tx k=%0d got %b want %b", k, tx, e); end
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL div_busy_end got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    int t0;
    bus_write(4'h8, 32'd4);
    bus_write(4'h0, 32'h5A);
    t0 = cyc;
    bus_write(4'h0, 32'h11);
    bus_write(4'h0, 32'h22);
    wait_cyc(t0 + 1 + 25);
    checks++;
    if (tx !== exp_bit(8'h5A, 6)) begin errors++; $display("FAIL rmid_bit5 got %b want %b", tx, exp_bit(8'h5A, 6)); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rmid_tx got %b want 1", tx); end
    bus_read(4'h4, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL rmid_status got %h want 4", d); end
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL rmid_quiet k=%0d tx=%b busy=%b want tx=1 busy=0", k, tx, busy);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_div_change;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
